// File: rtl/qmf_pkg.sv
// Shared types and helpers for the QMF coefficient/enable controller.
package qmf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_FLUSH,
    ST_RUN
  } qmf_ctrl_state_t;

  localparam int unsigned QMF_Q15_ONE = 32768;

  // Bit offset of tap k inside a flattened coefficient bank.
  function automatic int unsigned coef_idx(input int unsigned k, input int unsigned coefw);
    return k * coefw;
  endfunction

endpackage

// File: rtl/qmf_valid_delay.sv
// CORE_LAT-deep delay of the core enable, producing bands_valid; clr empties the line.
module qmf_valid_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/qmf_coef_ctrl.sv
// Coefficient shadow/active bank controller and core enable gating for the QMF analysis core.
// Define QMF_COEF_SYM_EN to stream only half the taps and mirror them on commit.
module qmf_coef_ctrl
  import qmf_pkg::*;
#(
  parameter int unsigned NTAPS    = 8,
  parameter int unsigned COEFW    = 16,
  parameter int unsigned CORE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic                     s_coef_valid,
  output logic                     s_coef_ready,
  input  logic [COEFW-1:0]         s_coef_data,
  input  logic                     s_coef_last,
  output logic                     core_en,
  output logic [NTAPS*COEFW-1:0]   h0_coef_flat,
  output logic                     bands_valid,
  output logic                     busy,
  output logic                     load_err
);

`ifdef QMF_COEF_SYM_EN
  localparam int unsigned NTAPS_LOAD = NTAPS / 2;
`else
  localparam int unsigned NTAPS_LOAD = NTAPS;
`endif
  localparam int unsigned CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NTAPS_LOAD - 1);
  localparam logic [CW-1:0] FLUSH_END = CW'(NTAPS - 1);

  qmf_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [CW-1:0]   beat_idx;
  logic            committed_q;
  logic            load_err_q, err_d;
  logic            wr_en;
  logic            beat;
  logic            bank_live;
  logic            vd_clr;
  logic [COEFW-1:0] shadow_q [NTAPS_LOAD];
  logic [COEFW-1:0] active_q [NTAPS];

  assign s_coef_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_COMMIT) || (state_q == ST_FLUSH);
  assign load_err     = load_err_q;
  assign beat         = s_coef_valid && s_coef_ready;
  // A fresh set always begins at tap 0, whether it starts from IDLE or RUN.
  assign beat_idx     = (state_q == ST_LOAD) ? cnt_q : '0;

  // The core keeps running on the old bank while a reload streams in.
  assign bank_live = (state_q == ST_RUN) || (state_q == ST_COMMIT) || (state_q == ST_FLUSH) ||
                     ((state_q == ST_LOAD) && committed_q);
  assign core_en   = sample_tick && bank_live;
  assign vd_clr    = (state_q == ST_COMMIT) || (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD, ST_RUN: begin
        if (beat) begin
          if (s_coef_last && (beat_idx == LAST_IDX)) begin
            wr_en   = 1'b1;
            cnt_d   = '0;
            state_d = ST_COMMIT;
          end else if (s_coef_last || (beat_idx >= LAST_IDX)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = committed_q ? ST_RUN : ST_IDLE;
          end else begin
            wr_en   = 1'b1;
            cnt_d   = beat_idx + CW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_FLUSH;
        fcnt_d  = sample_tick ? CW'(1) : '0;
      end
      ST_FLUSH: begin
        if (sample_tick) begin
          if (fcnt_q == FLUSH_END) begin
            fcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      committed_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NTAPS_LOAD; i++) shadow_q[i] <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) active_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      load_err_q <= err_d;
      for (int unsigned i = 0; i < NTAPS_LOAD; i++) begin
        if (wr_en && (beat_idx == CW'(i))) shadow_q[i] <= s_coef_data;
      end
      if (state_q == ST_COMMIT) begin
        committed_q <= 1'b1;
`ifdef QMF_COEF_SYM_EN
        for (int unsigned i = 0; i < NTAPS_LOAD; i++) begin
          active_q[i]           <= shadow_q[i];
          active_q[NTAPS-1-i]   <= shadow_q[i];
        end
`else
        for (int unsigned i = 0; i < NTAPS; i++) active_q[i] <= shadow_q[i];
`endif
      end
    end
  end

  always_comb begin
    h0_coef_flat = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      h0_coef_flat[coef_idx(k, COEFW) +: COEFW] = active_q[k];
    end
  end

  qmf_valid_delay #(
    .DEPTH(CORE_LAT)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (vd_clr),
    .din  (core_en),
    .dout (bands_valid)
  );

endmodule

// File: tb/tb_qmf_coef_ctrl.sv
// Self-checking bench for qmf_coef_ctrl (defaults NTAPS=8, COEFW=16, CORE_LAT=1).
module tb_qmf_coef_ctrl;

`ifdef QMF_COEF_SYM_EN
  localparam int NL = 4;
`else
  localparam int NL = 8;
`endif

  logic         clk = 1'b0;
  logic         rst, sample_tick, s_coef_valid, s_coef_last;
  logic [15:0]  s_coef_data;
  logic         s_coef_ready, core_en, bands_valid, busy, load_err;
  logic [127:0] h0_coef_flat;

  qmf_coef_ctrl #(.NTAPS(8), .COEFW(16), .CORE_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .s_coef_valid (s_coef_valid),
    .s_coef_ready (s_coef_ready),
    .s_coef_data  (s_coef_data),
    .s_coef_last  (s_coef_last),
    .core_en      (core_en),
    .h0_coef_flat (h0_coef_flat),
    .bands_valid  (bands_valid),
    .busy         (busy),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick, valid, last;
    logic [15:0] data;
    logic        en, rdy, bsy, err, bv, pop;
  } vec_t;

  vec_t         tbl[$];
  logic [127:0] sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [15:0]  j8 [8];
  logic [15:0]  set2 [8];
  logic [127:0] jfull, s2full, cur_bank;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic pop_bank(input string nm);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s got=empty_scoreboard exp=entry", nm);
    end else begin
      chk(nm, h0_coef_flat, sb.pop_front());
    end
  endtask

  task automatic drive(input logic r, input logic tk, input logic v, input logic [15:0] d, input logic l);
    @(posedge clk);
    #1;
    rst = r; sample_tick = tk; s_coef_valid = v; s_coef_data = d; s_coef_last = l;
    @(negedge clk);
  endtask

  function automatic void add(logic tk, logic v, logic [15:0] d, logic l,
                              logic en, logic rdy, logic bsy, logic bv, logic pop);
    vec_t x;
    x.tick = tk; x.valid = v; x.data = d; x.last = l;
    x.en = en; x.rdy = rdy; x.bsy = bsy; x.err = 1'b0; x.bv = bv; x.pop = pop;
    tbl.push_back(x);
  endfunction

  function automatic logic [127:0] mirror_bank(input logic [15:0] src [8]);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef QMF_COEF_SYM_EN
      r[k*16 +: 16] = (k < 4) ? src[k] : src[7-k];
`else
      r[k*16 +: 16] = src[k];
`endif
    end
    return r;
  endfunction

  initial begin
    j8[0] = 16'd308;   j8[1] = -16'sd2315; j8[2] = 16'd2275; j8[3] = 16'd16056;
    j8[4] = 16'd16056; j8[5] = 16'd2275;   j8[6] = -16'sd2315; j8[7] = 16'd308;
    for (int k = 0; k < 8; k++) set2[k] = 16'(k * 1000 + 7);
    jfull    = mirror_bank(j8);
    s2full   = mirror_bank(set2);
    cur_bank = '0;

    // Johnston load from IDLE, commit, 8-tick flush, then RUN.
    for (int b = 0; b < NL; b++)
      add(1'(b % 2), 1'b1, j8[b], (b == NL - 1), 1'b0, 1'b1, (b != 0), 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++)
      add(1'((i % 2) == 0), 1'b0, 16'h0, 1'b0, 1'((i % 2) == 0), 1'b0, 1'b1, 1'b0, (i == 0));
    add(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; sample_tick = 1'b0; s_coef_valid = 1'b0; s_coef_data = '0; s_coef_last = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst.ready", 128'(s_coef_ready), 128'(1));
    chk("rst.en",    128'(core_en),      128'(0));
    chk("rst.busy",  128'(busy),         128'(0));
    chk("rst.err",   128'(load_err),     128'(0));
    chk("rst.bv",    128'(bands_valid),  128'(0));
    chk("rst.bank",  h0_coef_flat,       128'(0));

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].tick, tbl[i].valid, tbl[i].data, tbl[i].last);
      if (tbl[i].valid && tbl[i].last) begin
        sb.push_back(cur_bank);
        sb.push_back(jfull);
        cur_bank = jfull;
      end
      chk($sformatf("r%0d.en", i),   128'(core_en),      128'(tbl[i].en));
      chk($sformatf("r%0d.rdy", i),  128'(s_coef_ready), 128'(tbl[i].rdy));
      chk($sformatf("r%0d.busy", i), 128'(busy),         128'(tbl[i].bsy));
      chk($sformatf("r%0d.err", i),  128'(load_err),     128'(tbl[i].err));
      chk($sformatf("r%0d.bv", i),   128'(bands_valid),  128'(tbl[i].bv));
      if (tbl[i].pop) pop_bank($sformatf("r%0d.bank", i));
    end
    chk("j8.tap0", 128'(h0_coef_flat[15:0]),    128'(308));
    chk("j8.tap7", 128'(h0_coef_flat[127:112]), 128'(308));

    // Early last: rejected, bank kept, back to RUN, core keeps ticking.
    for (int b = 0; b < NL - 3; b++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h1111, (b == NL - 4));
      chk($sformatf("early%0d.en", b), 128'(core_en), 128'(1));
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("early.err",  128'(load_err),     128'(1));
    chk("early.busy", 128'(busy),         128'(0));
    chk("early.rdy",  128'(s_coef_ready), 128'(1));
    chk("early.bank", h0_coef_flat,       jfull);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("early.err_end", 128'(load_err), 128'(0));

    // Overrun: NL beats without last; beat NL+1 opens a new load as tap 0.
    for (int b = 0; b <= NL; b++) begin
      drive(1'b0, 1'b0, 1'b1, (b == NL) ? set2[0] : 16'h5a5a, 1'b0);
      if (b == NL - 1) chk("ovr.err_pre", 128'(load_err), 128'(0));
    end
    chk("ovr.err",  128'(load_err), 128'(1));
    chk("ovr.busy", 128'(busy),     128'(0));

    // Reload during RUN continues from that tap 0.
    for (int b = 1; b < NL; b++) begin
      drive(1'b0, 1'b1, 1'b1, set2[b], (b == NL - 1));
      chk($sformatf("rl%0d.en", b),   128'(core_en),      128'(1));
      chk($sformatf("rl%0d.busy", b), 128'(busy),         128'(1));
      chk($sformatf("rl%0d.bank", b), h0_coef_flat,       jfull);
      if (b == 1) chk("rl.err_end", 128'(load_err), 128'(0));
    end
    sb.push_back(cur_bank);
    sb.push_back(s2full);
    cur_bank = s2full;
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("rl.commit.en",  128'(core_en),      128'(1));
    chk("rl.commit.rdy", 128'(s_coef_ready), 128'(0));
    pop_bank("rl.commit.bank");
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    pop_bank("rl.flush.bank");
    chk("rl.flush.bv", 128'(bands_valid), 128'(0));
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Reset on flush tick 3.
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk($sformatf("frst%0d.en", c), 128'(core_en), 128'(0));
      chk($sformatf("frst%0d.bv", c), 128'(bands_valid), 128'(0));
    end
    chk("frst.rdy",  128'(s_coef_ready), 128'(1));
    chk("frst.busy", 128'(busy),         128'(0));
    chk("frst.err",  128'(load_err),     128'(0));
    chk("frst.bank", h0_coef_flat,       128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
